exe_program_loader: RTL and testbench

//  Front-end controller sitting directly upstream of the execution unit.
//  - Streams a program into the execution unit's instruction memory write port.
//  - Pulses the execution unit's reset and holds its enable while the program runs.
//  - Watches for the halt indication and reports completion plus run-cycle count to the host.

---
 rtl/exe_program_loader_if.sv | 39 +++
 rtl/exe_program_loader.sv | 154 +++++++++++++++
 tb/tb_exe_program_loader.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_program_loader_if.sv
// Host/loader/execution-unit signal bundle for exe_program_loader.
// master = the loader itself, slave = host plus execution unit side.
interface exe_program_loader_if #(
  parameter int INSTR_W = 64,
  parameter int IADDR_W = 16,
  parameter int CNT_W   = 32
);
  // Load stream: a word moves on a rising edge where iLoadValid and oLoadReady
  // are both high; iLoadData must be stable whenever iLoadValid is high.
  logic               iLoadStart;
  logic [IADDR_W:0]   iLoadLength;
  logic [INSTR_W-1:0] iLoadData;
  logic               iLoadValid;
  logic               oLoadReady;
  logic               oIMWriteEnable;
  logic [IADDR_W-1:0] oIMWriteAddress;
  logic [INSTR_W-1:0] oIMData;
  logic               oExeReset;
  logic               oExeEnable;
  logic               iExeHalt;
  logic               iAbort;
  logic               oBusy;
  logic               oDone;
  logic               oError;
  logic [CNT_W-1:0]   oCycleCount;
  logic [2:0]         oDbgState;

  modport master (
    input  iLoadStart, iLoadLength, iLoadData, iLoadValid, iExeHalt, iAbort,
    output oLoadReady, oIMWriteEnable, oIMWriteAddress, oIMData, oExeReset,
           oExeEnable, oBusy, oDone, oError, oCycleCount, oDbgState
  );

  modport slave (
    output iLoadStart, iLoadLength, iLoadData, iLoadValid, iExeHalt, iAbort,
    input  oLoadReady, oIMWriteEnable, oIMWriteAddress, oIMData, oExeReset,
           oExeEnable, oBusy, oDone, oError, oCycleCount, oDbgState
  );
endinterface

// File: rtl/exe_program_loader.sv
// Streams a program into the execution unit, runs it, reports halt and cycle count.
// Optional run watchdog with ERR state: define EXE_WATCHDOG_EN.
module exe_program_loader #(
  parameter int INSTR_W     = 64,
  parameter int IADDR_W     = 16,
  parameter int CNT_W       = 32,
  parameter int WDOG_CYCLES = 1000000
) (
  input  logic                  Clock,
  input  logic                  Reset,
  exe_program_loader_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
`ifdef EXE_WATCHDOG_EN
    , ERR = 3'd5
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [IADDR_W:0]   len_q, len_d;
  logic [IADDR_W:0]   addr_cnt_q, addr_cnt_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic               wr_en_q, wr_en_d;
  logic [IADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [INSTR_W-1:0] wr_data_q, wr_data_d;
  logic               load_ready_q, load_ready_d;
  logic               exe_reset_q, exe_reset_d;
  logic               exe_enable_q, exe_enable_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               accept;

`ifdef EXE_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(WDOG_CYCLES);
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = |WDOG_CYCLES;
`endif

  assign accept = bus.iLoadValid & load_ready_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    addr_cnt_d  = addr_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.iLoadStart) begin
          len_d       = bus.iLoadLength;
          addr_cnt_d  = '0;
          cycle_cnt_d = '0;
          state_d     = (bus.iLoadLength != '0) ? LOAD : START;
        end
      end
      LOAD: begin
        // The write is registered, so the last word lands during START.
        if (accept) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = addr_cnt_q[IADDR_W-1:0];
          wr_data_d  = bus.iLoadData;
          addr_cnt_d = addr_cnt_q + (IADDR_W+1)'(1);
          if (addr_cnt_d == len_q) state_d = START;
        end
      end
      START: state_d = RUN;
      RUN: begin
        if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        if (bus.iExeHalt) state_d = DONE;
`ifdef EXE_WATCHDOG_EN
        else if (cycle_cnt_d == WDOG_LIMIT) state_d = ERR;
`endif
      end
`ifdef EXE_WATCHDOG_EN
      ERR: state_d = ERR;
`endif
      default: state_d = IDLE;
    endcase

    // Abort outranks everything but Reset, including a same-cycle halt.
    if (bus.iAbort) begin
      state_d     = IDLE;
      wr_en_d     = 1'b0;
      cycle_cnt_d = cycle_cnt_q;
    end

    load_ready_d = (state_d == LOAD);
    exe_reset_d  = (state_d == START);
    exe_enable_d = (state_d == RUN);
    busy_d       = (state_d != IDLE) && (state_d != DONE);
    done_d       = (state_d == DONE);
`ifdef EXE_WATCHDOG_EN
    error_d      = (state_d == ERR);
`else
    error_d      = 1'b0;
`endif
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      addr_cnt_q   <= '0;
      cycle_cnt_q  <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      load_ready_q <= 1'b0;
      exe_reset_q  <= 1'b0;
      exe_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      addr_cnt_q   <= addr_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      load_ready_q <= load_ready_d;
      exe_reset_q  <= exe_reset_d;
      exe_enable_q <= exe_enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.oLoadReady      = load_ready_q;
  assign bus.oIMWriteEnable  = wr_en_q;
  assign bus.oIMWriteAddress = wr_addr_q;
  assign bus.oIMData         = wr_data_q;
  assign bus.oExeReset       = exe_reset_q;
  assign bus.oExeEnable      = exe_enable_q;
  assign bus.oBusy           = busy_q;
  assign bus.oDone           = done_q;
  assign bus.oError          = error_q;
  assign bus.oCycleCount     = cycle_cnt_q;
  assign bus.oDbgState       = state_q;

endmodule

// File: tb/tb_exe_program_loader.sv
// Self-checking bench for exe_program_loader; IM writes go through an expected queue.
// Build with EXE_WATCHDOG_EN to exercise the watchdog/ERR path.
module tb_exe_program_loader;
  localparam int INSTR_W = 64;
  localparam int IADDR_W = 16;
  localparam int CNT_W   = 32;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   wr_seen  = 0;
  logic [IADDR_W+INSTR_W-1:0] exp_q[$];

  exe_program_loader_if #(.INSTR_W(INSTR_W), .IADDR_W(IADDR_W), .CNT_W(CNT_W)) bus ();

  exe_program_loader #(
    .INSTR_W(INSTR_W), .IADDR_W(IADDR_W), .CNT_W(CNT_W), .WDOG_CYCLES(20)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard: every IM write must match the oldest expected {addr, data}.
  always @(negedge clk) begin
    if (!rst && bus.oIMWriteEnable === 1'b1) begin
      wr_seen++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL im_write_unexpected: got addr=%0h data=%0h, want no write",
                 bus.oIMWriteAddress, bus.oIMData);
      end else begin
        logic [IADDR_W+INSTR_W-1:0] e;
        e = exp_q.pop_front();
        if ({bus.oIMWriteAddress, bus.oIMData} !== e) begin
          n_fail++;
          $display("FAIL im_write: got addr=%0h data=%0h, want addr=%0h data=%0h",
                   bus.oIMWriteAddress, bus.oIMData, e[IADDR_W+INSTR_W-1:INSTR_W], e[INSTR_W-1:0]);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_load(input logic [IADDR_W:0] len);
    bus.iLoadStart  = 1'b1;
    bus.iLoadLength = len;
    step();
    bus.iLoadStart  = 1'b0;
  endtask

  // Drives words following vpat (LSB first), checking ready and the write strobe each step.
  task automatic load_words(input int n, input logic [15:0] vpat,
                            input logic [INSTR_W-1:0] base, input logic extra_valid);
    int   sent = 0;
    int   k = 0;
    logic prev = 1'b0;
    logic v;
    while (sent < n && k < 16) begin
      n_checks++;
      if (bus.oLoadReady !== 1'b1) begin
        n_fail++; $display("FAIL load_ready: got %b, want 1 (step %0d)", bus.oLoadReady, k);
      end
      n_checks++;
      if (bus.oIMWriteEnable !== prev) begin
        n_fail++; $display("FAIL wr_strobe: got %b, want %b (step %0d)", bus.oIMWriteEnable, prev, k);
      end
      v = vpat[k];
      bus.iLoadValid = v;
      bus.iLoadData  = v ? base + INSTR_W'(sent) : INSTR_W'($urandom());
      if (v) begin
        exp_q.push_back({IADDR_W'(sent), base + INSTR_W'(sent)});
        sent++;
      end
      prev = v;
      k++;
      step();
    end
    bus.iLoadValid = extra_valid;
    bus.iLoadData  = INSTR_W'($urandom());
  endtask

  task automatic check_start_cycle(input string tag);
    n_checks++;
    if (bus.oDbgState !== S_START || bus.oExeReset !== 1'b1 || bus.oExeEnable !== 1'b0 ||
        bus.oLoadReady !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_start: got state=%0d rst=%b en=%b rdy=%b, want state=2 rst=1 en=0 rdy=0",
               tag, bus.oDbgState, bus.oExeReset, bus.oExeEnable, bus.oLoadReady);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_checks++;
    if ({bus.oLoadReady, bus.oIMWriteEnable, bus.oExeReset, bus.oExeEnable,
         bus.oBusy, bus.oDone, bus.oError} !== 7'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, want 0", {bus.oLoadReady, bus.oIMWriteEnable,
               bus.oExeReset, bus.oExeEnable, bus.oBusy, bus.oDone, bus.oError});
    end
    n_checks++;
    if (bus.oIMWriteAddress !== '0 || bus.oIMData !== '0 || bus.oCycleCount !== '0 ||
        bus.oDbgState !== S_IDLE) begin
      n_fail++; $display("FAIL reset_values: got addr=%0h data=%0h cnt=%0d state=%0d, want 0",
               bus.oIMWriteAddress, bus.oIMData, bus.oCycleCount, bus.oDbgState);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_load_run();
    start_load(17'd4);
    n_checks++;
    if (bus.oDbgState !== S_LOAD || bus.oBusy !== 1'b1) begin
      n_fail++; $display("FAIL t1_enter_load: got state=%0d busy=%b, want 1/1", bus.oDbgState, bus.oBusy);
    end
    load_words(4, 16'hFFFF, 64'hA0, 1'b1);
    check_start_cycle("t1");
    n_checks++;
    if (bus.oIMWriteEnable !== 1'b1) begin
      n_fail++; $display("FAIL t1_last_write: got %b, want 1", bus.oIMWriteEnable);
    end
    bus.iLoadValid = 1'b0;
    step();
    n_checks++;
    if (bus.oDbgState !== S_RUN || bus.oExeEnable !== 1'b1 || bus.oExeReset !== 1'b0 ||
        bus.oCycleCount !== 32'd0 || bus.oIMWriteEnable !== 1'b0) begin
      n_fail++; $display("FAIL t1_run_entry: got state=%0d en=%b rst=%b cnt=%0d we=%b, want 3/1/0/0/0",
               bus.oDbgState, bus.oExeEnable, bus.oExeReset, bus.oCycleCount, bus.oIMWriteEnable);
    end
    repeat (9) step();
    n_checks++;
    if (bus.oCycleCount !== 32'd9) begin
      n_fail++; $display("FAIL t1_count_mid: got %0d, want 9", bus.oCycleCount);
    end
    bus.iExeHalt = 1'b1;
    step();
    bus.iExeHalt = 1'b0;
    n_checks++;
    if (bus.oDbgState !== S_DONE || bus.oDone !== 1'b1 || bus.oCycleCount !== 32'd10 ||
        bus.oExeEnable !== 1'b0 || bus.oBusy !== 1'b0) begin
      n_fail++; $display("FAIL t1_done: got state=%0d done=%b cnt=%0d en=%b busy=%b, want 4/1/10/0/0",
               bus.oDbgState, bus.oDone, bus.oCycleCount, bus.oExeEnable, bus.oBusy);
    end
    n_checks++;
    if (wr_seen !== 4 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL t1_write_total: got %0d writes (%0d pending), want 4 (0)", wr_seen, exp_q.size());
    end
  endtask

  task automatic test_valid_gaps();
    start_load(17'd3);
    n_checks++;
    if (bus.oDone !== 1'b0 || bus.oDbgState !== S_LOAD) begin
      n_fail++; $display("FAIL t2_done_drop: got done=%b state=%0d, want 0/1", bus.oDone, bus.oDbgState);
    end
    load_words(3, 16'b1_0101, 64'hB000_0000_0000_0000, 1'b0);
    check_start_cycle("t2");
    step();
    bus.iExeHalt = 1'b1;
    step();
    bus.iExeHalt = 1'b0;
    n_checks++;
    if (bus.oDbgState !== S_DONE || bus.oCycleCount !== 32'd1 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL t2_done: got state=%0d cnt=%0d pending=%0d, want 4/1/0",
               bus.oDbgState, bus.oCycleCount, exp_q.size());
    end
  endtask

  task automatic test_rerun();
    start_load(17'd0);
    check_start_cycle("t3");
    n_checks++;
    if (bus.oCycleCount !== 32'd0 || bus.oDone !== 1'b0 || bus.oIMWriteEnable !== 1'b0) begin
      n_fail++; $display("FAIL t3_clear: got cnt=%0d done=%b we=%b, want 0/0/0",
               bus.oCycleCount, bus.oDone, bus.oIMWriteEnable);
    end
    step(); step(); step();
    bus.iExeHalt = 1'b1;
    step();
    bus.iExeHalt = 1'b0;
    n_checks++;
    if (bus.oDbgState !== S_DONE || bus.oCycleCount !== 32'd3) begin
      n_fail++; $display("FAIL t3_done: got state=%0d cnt=%0d, want 4/3", bus.oDbgState, bus.oCycleCount);
    end
  endtask

  task automatic test_abort();
    start_load(17'd5);
    bus.iLoadValid = 1'b1; bus.iLoadData = 64'hC0;
    exp_q.push_back({16'd0, 64'hC0});
    step();
    bus.iLoadData = 64'hC1;
    exp_q.push_back({16'd1, 64'hC1});
    step();
    bus.iAbort = 1'b1; bus.iLoadData = 64'hC2;
    step();
    bus.iAbort = 1'b0; bus.iLoadValid = 1'b0;
    n_checks++;
    if (bus.oDbgState !== S_IDLE || bus.oLoadReady !== 1'b0 || bus.oIMWriteEnable !== 1'b0 ||
        bus.oBusy !== 1'b0 || bus.oDone !== 1'b0) begin
      n_fail++; $display("FAIL t4_abort_load: got state=%0d rdy=%b we=%b busy=%b done=%b, want 0/0/0/0/0",
               bus.oDbgState, bus.oLoadReady, bus.oIMWriteEnable, bus.oBusy, bus.oDone);
    end
    step();
    start_load(17'd0);
    step(); step(); step();
    bus.iAbort = 1'b1; bus.iExeHalt = 1'b1;
    step();
    bus.iAbort = 1'b0; bus.iExeHalt = 1'b0;
    n_checks++;
    if (bus.oDbgState !== S_IDLE || bus.oDone !== 1'b0 || bus.oExeEnable !== 1'b0 ||
        bus.oCycleCount !== 32'd2) begin
      n_fail++; $display("FAIL t4_abort_halt: got state=%0d done=%b en=%b cnt=%0d, want 0/0/0/2",
               bus.oDbgState, bus.oDone, bus.oExeEnable, bus.oCycleCount);
    end
  endtask

  task automatic test_ignored_inputs();
    start_load(17'd0);
    step(); step();
    bus.iLoadStart = 1'b1; bus.iLoadLength = 17'd2;
    step();
    bus.iLoadStart = 1'b0;
    n_checks++;
    if (bus.oDbgState !== S_RUN || bus.oExeEnable !== 1'b1 || bus.oLoadReady !== 1'b0 ||
        bus.oExeReset !== 1'b0 || bus.oCycleCount !== 32'd2) begin
      n_fail++; $display("FAIL t5_start_in_run: got state=%0d en=%b rdy=%b rst=%b cnt=%0d, want 3/1/0/0/2",
               bus.oDbgState, bus.oExeEnable, bus.oLoadReady, bus.oExeReset, bus.oCycleCount);
    end
    bus.iAbort = 1'b1;
    step();
    bus.iAbort = 1'b0; bus.iExeHalt = 1'b1;
    step();
    bus.iExeHalt = 1'b0;
    n_checks++;
    if (bus.oDbgState !== S_IDLE || bus.oDone !== 1'b0 || bus.oBusy !== 1'b0 || bus.oExeEnable !== 1'b0) begin
      n_fail++; $display("FAIL t5_halt_in_idle: got state=%0d done=%b busy=%b en=%b, want 0/0/0/0",
               bus.oDbgState, bus.oDone, bus.oBusy, bus.oExeEnable);
    end
  endtask

  task automatic test_watchdog();
    start_load(17'd0);
    step();
    repeat (20) step();
`ifdef EXE_WATCHDOG_EN
    n_checks++;
    if (bus.oDbgState !== S_ERR || bus.oError !== 1'b1 || bus.oExeEnable !== 1'b0 ||
        bus.oCycleCount !== 32'd20 || bus.oBusy !== 1'b1) begin
      n_fail++; $display("FAIL t6_wdog_err: got state=%0d err=%b en=%b cnt=%0d busy=%b, want 5/1/0/20/1",
               bus.oDbgState, bus.oError, bus.oExeEnable, bus.oCycleCount, bus.oBusy);
    end
    bus.iLoadStart = 1'b1; bus.iLoadLength = 17'd0;
    step();
    bus.iLoadStart = 1'b0;
    n_checks++;
    if (bus.oDbgState !== S_ERR) begin
      n_fail++; $display("FAIL t6_err_sticky: got state=%0d, want 5", bus.oDbgState);
    end
`else
    n_checks++;
    if (bus.oDbgState !== S_RUN || bus.oExeEnable !== 1'b1 || bus.oCycleCount !== 32'd20 ||
        bus.oError !== 1'b0) begin
      n_fail++; $display("FAIL t6_no_wdog: got state=%0d en=%b cnt=%0d err=%b, want 3/1/20/0",
               bus.oDbgState, bus.oExeEnable, bus.oCycleCount, bus.oError);
    end
    repeat (5) step();
    n_checks++;
    if (bus.oDbgState !== S_RUN || bus.oCycleCount !== 32'd25) begin
      n_fail++; $display("FAIL t6_run_long: got state=%0d cnt=%0d, want 3/25", bus.oDbgState, bus.oCycleCount);
    end
`endif
    bus.iAbort = 1'b1;
    step();
    bus.iAbort = 1'b0;
    n_checks++;
    if (bus.oDbgState !== S_IDLE || bus.oError !== 1'b0 || bus.oExeEnable !== 1'b0) begin
      n_fail++; $display("FAIL t6_abort_exit: got state=%0d err=%b en=%b, want 0/0/0",
               bus.oDbgState, bus.oError, bus.oExeEnable);
    end
  endtask

  task automatic test_reset_mid();
    start_load(17'd4);
    bus.iLoadValid = 1'b1; bus.iLoadData = 64'hD0;
    exp_q.push_back({16'd0, 64'hD0});
    step();
    bus.iLoadValid = 1'b0;
    rst = 1'b1;
    step();
    n_checks++;
    if (bus.oDbgState !== S_IDLE || bus.oLoadReady !== 1'b0 || bus.oIMWriteEnable !== 1'b0 ||
        bus.oIMWriteAddress !== '0 || bus.oIMData !== '0 || bus.oBusy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: got state=%0d rdy=%b we=%b addr=%0h data=%0h busy=%b, want all 0",
               bus.oDbgState, bus.oLoadReady, bus.oIMWriteEnable, bus.oIMWriteAddress, bus.oIMData, bus.oBusy);
    end
    rst = 1'b0;
    step();
  endtask

  initial begin
    bus.iLoadStart  = 1'b0;
    bus.iLoadLength = '0;
    bus.iLoadData   = '0;
    bus.iLoadValid  = 1'b0;
    bus.iExeHalt    = 1'b0;
    bus.iAbort      = 1'b0;
    test_reset();
    test_load_run();
    test_valid_gaps();
    test_rerun();
    test_abort();
    test_ignored_inputs();
    test_watchdog();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d pending writes, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
